// File: rtl/pipe_stage_hs_pkg.sv
// Shared types and default widths for the handshaked pipeline stage.
// Widths track the CPU's register-data and instruction-address definitions.
package pipe_pkg;

  localparam int RegDataWidth  = 64;
  localparam int InstAddrWidth = 64;
  localparam int CtrlWidth     = 16;
  localparam int StallCntWidth = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  // All-zero control encodes a NOP bubble.
  localparam logic [CtrlWidth-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_stage_hs_sat_counter.sv
// Saturating up-counter with synchronous clear, reused for performance counters.
// Count visible one cycle after inc; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, optional skid entry, hold and flush-to-bubble.
// Latency 1 cycle; SKID=1 registers in_ready and absorbs one entry after out_ready drops, SKID=0 passes out_ready through.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = RegDataWidth,
  parameter int CTRL_WIDTH = CtrlWidth,
  parameter int SKID       = 1,
  parameter int CNT_WIDTH  = StallCntWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [CTRL_WIDTH-1:0] in_ctrl_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [CTRL_WIDTH-1:0] out_ctrl_o,
  input  logic                  hold_i,
  input  logic                  flush_i,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, skid_data;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d, skid_ctrl;
  logic                  in_fire, out_fire, skid_load, stall_inc;

  assign out_valid_o = (state_q != pipe_pkg::EMPTY) & ~hold_i & ~rst_i;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;
  assign skid_load   = in_fire & ~out_fire & (state_q == pipe_pkg::FULL);

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_WIDTH-1:0] skid_data_q;
      logic [CTRL_WIDTH-1:0] skid_ctrl_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          skid_data_q <= '0;
          skid_ctrl_q <= CTRL_WIDTH'(CTRL_NOP);
        end else if (flush_i) begin
          skid_ctrl_q <= CTRL_WIDTH'(CTRL_NOP);
        end else if (skid_load) begin
          skid_data_q <= in_data_i;
          skid_ctrl_q <= in_ctrl_i;
        end
      end

      assign skid_data  = skid_data_q;
      assign skid_ctrl  = skid_ctrl_q;
      // Decoded from state only, so out_ready never reaches in_ready.
      assign in_ready_o = (state_q != pipe_pkg::SKID) & ~hold_i & ~flush_i & ~rst_i;
    end else begin : g_noskid
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
      assign in_ready_o = ((state_q == pipe_pkg::EMPTY) | out_ready_i) & ~hold_i & ~flush_i & ~rst_i;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush_i) begin
      // Payload is kept; only control is cleared to make a bubble.
      state_d = pipe_pkg::EMPTY;
      ctrl_d  = CTRL_WIDTH'(CTRL_NOP);
    end else begin
      case (state_q)
        pipe_pkg::EMPTY: begin
          if (in_fire) begin
            state_d = pipe_pkg::FULL;
            data_d  = in_data_i;
            ctrl_d  = in_ctrl_i;
          end
        end
        pipe_pkg::FULL: begin
          if (in_fire && out_fire) begin
            data_d = in_data_i;
            ctrl_d = in_ctrl_i;
          end else if (skid_load) begin
            state_d = pipe_pkg::SKID;
          end else if (out_fire) begin
            state_d = pipe_pkg::EMPTY;
          end
        end
        pipe_pkg::SKID: begin
          if (out_fire) begin
            state_d = pipe_pkg::FULL;
            data_d  = skid_data;
            ctrl_d  = skid_ctrl;
          end
        end
        default: state_d = pipe_pkg::EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= pipe_pkg::EMPTY;
      data_q  <= '0;
      ctrl_q  <= CTRL_WIDTH'(CTRL_NOP);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_data_o = data_q;
  assign out_ctrl_o = ctrl_q;

  assign stall_inc = (hold_i | ((state_q != pipe_pkg::EMPTY) & ~out_ready_i)) & ~flush_i;

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (stall_inc),
    .clr_i  (1'b0),
    .count_o(stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: skid variant scoreboarded end to end, plus a
// single-entry variant with a 4-bit counter sharing the same stimulus.
module tb_pipe_stage_hs;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_ready;
  logic        hold;
  logic        flush;

  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic [15:0] out_ctrl;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [63:0] s_out_data;
  logic [15:0] s_out_ctrl;
  logic [3:0]  s_stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  logic [79:0] sb_q[$];

  pipe_stage_hs #(.DATA_WIDTH(64), .CTRL_WIDTH(16), .SKID(1), .CNT_WIDTH(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .out_ctrl_o(out_ctrl),
    .hold_i(hold), .flush_i(flush), .stall_cnt_o(stall_cnt)
  );

  pipe_stage_hs #(.DATA_WIDTH(64), .CTRL_WIDTH(16), .SKID(0), .CNT_WIDTH(4)) u_sat (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl), .out_valid_o(s_out_valid),
    .out_ready_i(out_ready), .out_data_o(s_out_data), .out_ctrl_o(s_out_ctrl),
    .hold_i(hold), .flush_i(flush), .stall_cnt_o(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accept, pop and compare on delivery, drop all on flush.
  always @(negedge clk) begin
    if (!rst) begin
      if (flush) begin
        sb_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) check_eq("sb_unexpected_out", {out_ctrl, out_data}, '0);
          else check_eq("sb_order", {out_ctrl, out_data}, sb_q.pop_front());
        end
        if (in_valid && in_ready) sb_q.push_back({in_ctrl, in_data});
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 64'hDEAD; in_ctrl = 16'hFFFF;
    out_ready = 1'b0; hold = 1'b0; flush = 1'b0;

    // Reset
    @(posedge clk); @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_data", out_data, 64'd0);
    check_eq("rst_out_ctrl", out_ctrl, 16'd0);
    check_eq("rst_stall_cnt", stall_cnt, 16'd0);
    check_eq("rst_sat_cnt", s_stall_cnt, 4'd0);
    tick(); rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("rel_in_ready", in_ready, 1'b1);
    check_eq("rel_out_valid", out_valid, 1'b0);

    // Streaming 0..7 with out_ready high
    for (int i = 0; i < 8; i++) begin
      tick(); in_valid = 1'b1; in_data = 64'(i); in_ctrl = 16'h0100 | 16'(i); out_ready = 1'b1;
      @(negedge clk);
      check_eq("stream_in_ready", in_ready, 1'b1);
      check_eq("stream_out_valid", out_valid, i != 0);
      if (i > 0) check_eq("stream_out_data", out_data, 64'(i - 1));
    end
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check_eq("stream_last_valid", out_valid, 1'b1);
    check_eq("stream_last_data", out_data, 64'd7);
    tick(); @(negedge clk);
    check_eq("stream_drained", out_valid, 1'b0);
    check_eq("stream_stall", stall_cnt, 16'd0);

    // Back-pressure: A accepted into empty stage, B into skid, C refused
    tick(); in_valid = 1'b1; in_data = 64'd1; in_ctrl = 16'h0A01; out_ready = 1'b1;
    @(negedge clk); check_eq("bp_accept_a", in_ready, 1'b1);
    tick(); in_data = 64'd2; in_ctrl = 16'h0A02; out_ready = 1'b0;
    @(negedge clk); check_eq("bp_accept_b", in_ready, 1'b1);
    check_eq("bp_head_a", out_data, 64'd1);
    tick(); in_data = 64'd3; in_ctrl = 16'h0A03;
    @(negedge clk); check_eq("bp_refuse_c", in_ready, 1'b0);
    check_eq("bp_valid", out_valid, 1'b1);
    tick(); out_ready = 1'b1;
    @(negedge clk); check_eq("bp_skid_rdy", in_ready, 1'b0);
    check_eq("bp_out_a", out_data, 64'd1);
    tick(); @(negedge clk);
    check_eq("bp_c_rdy", in_ready, 1'b1);
    check_eq("bp_out_b", out_data, 64'd2);
    tick(); in_valid = 1'b0;
    @(negedge clk); check_eq("bp_out_c", out_data, 64'd3);
    tick(); @(negedge clk);
    check_eq("bp_empty", out_valid, 1'b0);
    check_eq("bp_stall", stall_cnt, 16'd2);

    // Hold for 3 cycles while FULL with data 5
    tick(); in_valid = 1'b1; in_data = 64'd5; in_ctrl = 16'h0505; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); hold = 1'b1; in_data = 64'd6; in_ctrl = 16'h0606;
      @(negedge clk);
      check_eq("hold_out_valid", out_valid, 1'b0);
      check_eq("hold_in_ready", in_ready, 1'b0);
      check_eq("hold_out_data", out_data, 64'd5);
    end
    tick(); hold = 1'b0;
    @(negedge clk);
    check_eq("hold_release_valid", out_valid, 1'b1);
    check_eq("hold_release_data", out_data, 64'd5);
    tick(); in_valid = 1'b0;
    @(negedge clk); check_eq("hold_next_data", out_data, 64'd6);
    tick(); @(negedge clk);
    check_eq("hold_stall", stall_cnt, 16'd5);

    // Flush while in SKID state
    tick(); in_valid = 1'b1; in_data = 64'd7; in_ctrl = 16'hFFFF; out_ready = 1'b0;
    tick(); in_data = 64'd8;
    tick(); in_data = 64'd9;
    @(negedge clk); check_eq("fl_skid_full", in_ready, 1'b0);
    tick(); flush = 1'b1;
    @(negedge clk); check_eq("fl_in_ready", in_ready, 1'b0);
    tick(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("fl_out_valid", out_valid, 1'b0);
    check_eq("fl_out_ctrl", out_ctrl, 16'd0);
    check_eq("fl_out_data", out_data, 64'd7);
    check_eq("fl_in_ready_after", in_ready, 1'b1);
    check_eq("fl_stall", stall_cnt, 16'd7);

    // Flush together with hold: flush must win
    tick(); in_valid = 1'b1; in_data = 64'd10; in_ctrl = 16'h0A0A;
    tick(); hold = 1'b1; flush = 1'b1; in_data = 64'd11;
    @(negedge clk);
    check_eq("fh_in_ready", in_ready, 1'b0);
    check_eq("fh_out_valid", out_valid, 1'b0);
    tick(); hold = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("fh_after_valid", out_valid, 1'b0);
    check_eq("fh_after_ctrl", out_ctrl, 16'd0);
    check_eq("fh_after_data", out_data, 64'd10);
    check_eq("fh_stall", stall_cnt, 16'd7);

    // Saturation: both stages hold one entry with out_ready low for 20 cycles
    tick(); in_valid = 1'b1; in_data = 64'd12; in_ctrl = 16'h0C0C;
    for (int k = 0; k < 20; k++) begin
      tick(); in_valid = 1'b0;
    end
    @(negedge clk);
    check_eq("sat_cnt", s_stall_cnt, 4'hF);
    check_eq("sat_in_ready_blocked", s_in_ready, 1'b0);
    check_eq("sat_wide_cnt", stall_cnt, 16'd26);
    tick(); out_ready = 1'b1;
    @(negedge clk);
    check_eq("sat_no_wrap", s_stall_cnt, 4'hF);
    check_eq("sat_comb_in_ready", s_in_ready, 1'b1);
    check_eq("sat_s_out_data", s_out_data, 64'd12);
    check_eq("sat_wide_cnt_final", stall_cnt, 16'd27);
    tick(); @(negedge clk);
    check_eq("final_empty", out_valid, 1'b0);
    check_eq("sb_drained", 80'(sb_q.size()), 80'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
